// File: rtl/car_sequencer.sv
// Microsequencer front end: instruction decode to an entry CAR, the CAR register, and the
// MSP430 R2/R3 constant generator. Optional macro CAR_ILLEGAL_TRAP_EN sends illegal opcodes to CAR_RESET0.
module car_sequencer #(
    parameter int unsigned CAR_BITS = 7
) (
    input  logic                MCLK,
    input  logic                reset,
    input  logic [15:0]         IW,
    input  logic                blank,
    input  logic                INTREQ,
    input  logic                IF,
    input  logic                Br,
    input  logic                Format,
    input  logic [3:0]          srcA,
    input  logic [3:0]          dstA,
    input  logic [1:0]          As,
    input  logic                Ad,
    output logic [CAR_BITS-1:0] CAR,
    output logic [CAR_BITS-1:0] CARnew,
    output logic [15:0]         CGsrc,
    output logic [15:0]         CGdst,
    output logic                CGsrcGen,
    output logic                CGdstGen
);

    localparam logic [CAR_BITS-1:0] CAR_RESET0  = 7'h00;
    localparam logic [CAR_BITS-1:0] CAR_FETCH   = 7'h01;
    localparam logic [CAR_BITS-1:0] CAR_INT0    = 7'h04;
    localparam logic [CAR_BITS-1:0] CAR_RETI0   = 7'h08;
    localparam logic [CAR_BITS-1:0] CAR_BLANK   = 7'h0C;
    localparam logic [CAR_BITS-1:0] CAR_ILLEGAL = 7'h7C;
    localparam logic [CAR_BITS-1:0] CAR_JMP     = 7'h10;

`ifdef CAR_ILLEGAL_TRAP_EN
    localparam logic [CAR_BITS-1:0] CAR_ILL_ENTRY = CAR_RESET0;
`else
    localparam logic [CAR_BITS-1:0] CAR_ILL_ENTRY = CAR_ILLEGAL;
`endif

    logic [CAR_BITS-1:0] car_q;
    logic [CAR_BITS-1:0] car_d;
    logic [CAR_BITS-1:0] car_new;

    // Opcode bits that never influence the entry address.
    logic unused_iw;
    assign unused_iw = ^{IW[6], IW[3:0]};

    always_comb begin
        car_new = CAR_ILL_ENTRY;
        if (IW[15:13] == 3'b001) begin
            car_new = CAR_JMP;
        end else if (IW[15:12] >= 4'd4) begin
            car_new = {(Ad ? 3'b110 : 3'b101), IW[5:4], 2'b00};
        end else if (IW[15:10] == 6'b000100) begin
            case (IW[9:7])
                3'd0, 3'd1, 3'd2, 3'd3: car_new = {3'b010, IW[5:4], 2'b00};
                3'd4:                   car_new = {3'b011, IW[5:4], 2'b00};
                3'd5:                   car_new = {3'b100, IW[5:4], 2'b00};
                3'd6:                   car_new = CAR_RETI0;
                default:                car_new = CAR_ILL_ENTRY;
            endcase
        end
    end

    always_comb begin
        car_d = car_q + 7'd1;
        if (blank) begin
            car_d = CAR_BLANK;
        end else if (IF && INTREQ) begin
            car_d = CAR_INT0;
        end else if (IF && Br) begin
            car_d = CAR_FETCH;
        end else if (IF) begin
            car_d = car_new;
        end
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            car_q <= CAR_RESET0;
        end else begin
            car_q <= car_d;
        end
    end

    // Returns {generated, constant} for a register field addressed with mode as_mode.
    function automatic logic [16:0] cg_table(input logic [3:0] ra, input logic [1:0] as_mode);
        logic [16:0] r;
        r = 17'd0;
        if (ra == 4'd2) begin
            case (as_mode)
                2'b01:   r = {1'b1, 16'h0000};
                2'b10:   r = {1'b1, 16'h0004};
                2'b11:   r = {1'b1, 16'h0008};
                default: r = 17'd0;
            endcase
        end else if (ra == 4'd3) begin
            case (as_mode)
                2'b00:   r = {1'b1, 16'h0000};
                2'b01:   r = {1'b1, 16'h0001};
                2'b10:   r = {1'b1, 16'h0002};
                default: r = {1'b1, 16'hFFFF};
            endcase
        end
        return r;
    endfunction

    logic [16:0] cg_src_sel;
    logic [16:0] cg_dst_sel;

    always_comb begin
        cg_src_sel = 17'd0;
        cg_dst_sel = 17'd0;
        if (Format) begin
            // Single-operand forms carry their operand in the destination field.
            cg_dst_sel = cg_table(dstA, As);
        end else begin
            cg_src_sel = cg_table(srcA, As);
            if ((dstA == 4'd3) || ((dstA == 4'd2) && Ad)) begin
                cg_dst_sel = {1'b1, 16'h0000};
            end
        end
    end

    assign CAR      = car_q;
    assign CARnew   = car_new;
    assign CGsrcGen = cg_src_sel[16];
    assign CGsrc    = cg_src_sel[15:0];
    assign CGdstGen = cg_dst_sel[16];
    assign CGdst    = cg_dst_sel[15:0];

endmodule

// File: tb/tb_car_sequencer.sv
// Directed bench for car_sequencer: CAR sequencing, decode entries and constant generator.
module tb_car_sequencer;

    logic        MCLK = 1'b0;
    logic        reset;
    logic [15:0] IW;
    logic        blank, INTREQ, IF, Br, Format, Ad;
    logic [3:0]  srcA, dstA;
    logic [1:0]  As;
    logic [6:0]  CAR, CARnew;
    logic [15:0] CGsrc, CGdst;
    logic        CGsrcGen, CGdstGen;

    int errors = 0;
    int checks = 0;

`ifdef CAR_ILLEGAL_TRAP_EN
    localparam logic [6:0] EXP_ILL = 7'h00;
`else
    localparam logic [6:0] EXP_ILL = 7'h7C;
`endif

    car_sequencer dut (
        .MCLK(MCLK), .reset(reset), .IW(IW), .blank(blank), .INTREQ(INTREQ),
        .IF(IF), .Br(Br), .Format(Format), .srcA(srcA), .dstA(dstA),
        .As(As), .Ad(Ad), .CAR(CAR), .CARnew(CARnew), .CGsrc(CGsrc),
        .CGdst(CGdst), .CGsrcGen(CGsrcGen), .CGdstGen(CGdstGen)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    initial begin
        reset = 1'b0; IW = 16'h0000; blank = 1'b0; INTREQ = 1'b0; IF = 1'b0;
        Br = 1'b0; Format = 1'b0; Ad = 1'b0; srcA = 4'd0; dstA = 4'd0; As = 2'd0;

        // Reset and release
        tick();
        chk("reset_car", {9'd0, CAR}, 16'h0000);
        @(negedge MCLK);
        reset = 1'b1;
        tick();
        chk("release_car", {9'd0, CAR}, 16'h0001);

        // MOV R10,R11 then sequential stepping
        IW = 16'h4A0B; srcA = 4'hA; dstA = 4'hB; IF = 1'b1;
        #1;
        chk("mov_carnew", {9'd0, CARnew}, 16'h0050);
        tick();
        chk("mov_car", {9'd0, CAR}, 16'h0050);
        IF = 1'b0;
        tick();
        chk("step_51", {9'd0, CAR}, 16'h0051);
        tick();
        chk("step_52", {9'd0, CAR}, 16'h0052);

        // Decode entries
        IF = 1'b1; IW = 16'h1300;
        #1;
        chk("reti_carnew", {9'd0, CARnew}, 16'h0008);
        tick();
        chk("reti_car", {9'd0, CAR}, 16'h0008);
        IW = 16'h2400;
        tick();
        chk("jmp_car", {9'd0, CAR}, 16'h0010);
        IW = 16'h12B0;
        tick();
        chk("call_car", {9'd0, CAR}, 16'h004C);
        IW = 16'h1000;
        #1;
        chk("rrc_carnew", {9'd0, CARnew}, 16'h0020);
        IW = 16'h1220;
        #1;
        chk("push_carnew", {9'd0, CARnew}, 16'h0038);
        IW = 16'h5A9B; Ad = 1'b1;
        #1;
        chk("fmt1ad_carnew", {9'd0, CARnew}, 16'h0064);
        Ad = 1'b0;

        // Interrupt and branch priority
        IW = 16'h4A0B; INTREQ = 1'b1; Br = 1'b1;
        tick();
        chk("int_car", {9'd0, CAR}, 16'h0004);
        INTREQ = 1'b0;
        tick();
        chk("br_car", {9'd0, CAR}, 16'h0001);
        Br = 1'b0;

        // Blank forces and holds
        blank = 1'b1;
        tick();
        chk("blank_car", {9'd0, CAR}, 16'h000C);
        tick();
        chk("blank_hold", {9'd0, CAR}, 16'h000C);
        IF = 1'b0;
        tick();
        chk("blank_hold_if0", {9'd0, CAR}, 16'h000C);
        blank = 1'b0;

        // Wrap from 0x7F to 0x00
        IF = 1'b1; IW = 16'h2400;
        tick();
        IF = 1'b0;
        repeat (111) tick();
        chk("car_7f", {9'd0, CAR}, 16'h007F);
        tick();
        chk("car_wrap", {9'd0, CAR}, 16'h0000);

        // Async reset mid-run at 0x2A
        IF = 1'b1; IW = 16'h2400;
        tick();
        IF = 1'b0;
        repeat (26) tick();
        chk("car_2a", {9'd0, CAR}, 16'h002A);
        #3 reset = 1'b0;
        #1;
        chk("async_reset", {9'd0, CAR}, 16'h0000);
        @(negedge MCLK);
        reset = 1'b1;
        tick();
        chk("rerelease_car", {9'd0, CAR}, 16'h0001);

        // Illegal opcodes
        IF = 1'b1; IW = 16'h0000;
        #1;
        chk("ill_carnew", {9'd0, CARnew}, {9'd0, EXP_ILL});
        tick();
        chk("ill_car", {9'd0, CAR}, {9'd0, EXP_ILL});
        IW = 16'h1380;
        #1;
        chk("op7_carnew", {9'd0, CARnew}, {9'd0, EXP_ILL});
        IF = 1'b0;
        tick();
        chk("ill_step", {9'd0, CAR}, {9'd0, EXP_ILL + 7'd1});

        // Constant generator, format I
        Format = 1'b0; dstA = 4'd5; Ad = 1'b0;
        srcA = 4'd3; As = 2'b11; #1;
        chk("cg_r3_11", CGsrc, 16'hFFFF);
        chk("cg_r3_11_gen", {15'd0, CGsrcGen}, 16'd1);
        srcA = 4'd3; As = 2'b01; #1;
        chk("cg_r3_01", CGsrc, 16'h0001);
        srcA = 4'd2; As = 2'b10; #1;
        chk("cg_r2_10", CGsrc, 16'h0004);
        srcA = 4'd2; As = 2'b11; #1;
        chk("cg_r2_11", CGsrc, 16'h0008);
        srcA = 4'd2; As = 2'b00; #1;
        chk("cg_r2_00_gen", {15'd0, CGsrcGen}, 16'd0);
        chk("cg_r2_00_val", CGsrc, 16'h0000);
        srcA = 4'd4; As = 2'b11; #1;
        chk("cg_r4_gen", {15'd0, CGsrcGen}, 16'd0);
        chk("cg_dst5_gen", {15'd0, CGdstGen}, 16'd0);
        dstA = 4'd2; Ad = 1'b1; #1;
        chk("cgd_r2_ad1", {15'd0, CGdstGen}, 16'd1);
        dstA = 4'd2; Ad = 1'b0; #1;
        chk("cgd_r2_ad0", {15'd0, CGdstGen}, 16'd0);
        dstA = 4'd3; #1;
        chk("cgd_r3", {15'd0, CGdstGen}, 16'd1);

        // Constant generator, format II
        Format = 1'b1; srcA = 4'd3; dstA = 4'd3; As = 2'b01; #1;
        chk("f2_r3_01", CGdst, 16'h0001);
        chk("f2_r3_gen", {15'd0, CGdstGen}, 16'd1);
        chk("f2_src_gen", {15'd0, CGsrcGen}, 16'd0);
        dstA = 4'd2; As = 2'b10; #1;
        chk("f2_r2_10", CGdst, 16'h0004);
        As = 2'b00; #1;
        chk("f2_r2_00_gen", {15'd0, CGdstGen}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
